// File: rtl/rv_muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state encoding and funct3 decode helpers.
package rv_muldiv_pkg;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction

  function automatic logic is_signed_op1(input logic [2:0] f);
    return (f == F_MULH) || (f == F_MULHSU) || (f == F_DIV) || (f == F_REM);
  endfunction

  function automatic logic is_signed_op2(input logic [2:0] f);
    return (f == F_MULH) || (f == F_DIV) || (f == F_REM);
  endfunction

  // High word of the product for MULH*, remainder (also kept in the high
  // half of the shared accumulator) for REM*.
  function automatic logic sel_high(input logic [2:0] f);
    return (f != F_MUL) && (f != F_DIV) && (f != F_DIVU);
  endfunction

endpackage

// File: rtl/rv_muldiv_sign_prep.sv
// Combinational operand preparation for the M-extension datapath.
//   funct_i      funct3 of the operation
//   op1_i/op2_i  raw rs1/rs2 values
//   mag1_o/2_o   operand magnitudes (absolute value for signed operands)
//   neg_o        final result must be two's-complement negated
//   div_zero_o   divide/remainder by zero
//   ovf_o        signed divide overflow (most-negative / -1)
module rv_muldiv_sign_prep
  import rv_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  output logic [XLEN-1:0] mag1_o,
  output logic [XLEN-1:0] mag2_o,
  output logic            neg_o,
  output logic            div_zero_o,
  output logic            ovf_o
);

  logic s1, s2;

  assign s1     = is_signed_op1(funct_i) & op1_i[XLEN-1];
  assign s2     = is_signed_op2(funct_i) & op2_i[XLEN-1];
  assign mag1_o = s1 ? -op1_i : op1_i;
  assign mag2_o = s2 ? -op2_i : op2_i;

  // Low word of MUL is identical for signed and unsigned operands, so it
  // runs on raw operands and never negates. Remainder follows the dividend.
  always_comb begin
    neg_o = s1 ^ s2;
    if (funct_i == F_MUL)                          neg_o = 1'b0;
    else if (funct_i == F_REM || funct_i == F_REMU) neg_o = s1;
  end

  assign div_zero_o = is_div(funct_i) && (op2_i == '0);
  assign ovf_o      = ((funct_i == F_DIV) || (funct_i == F_REM)) &&
                      (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);

endmodule

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: XLEN shift-add / restoring-divide
// steps, one sign/word fix-up cycle, then a held result until consumed.
//   clk, rst              clock, async active-high reset
//   in_valid/in_ready     request handshake (ready only in IDLE)
//   funct, op1, op2       funct3 and operands, latched at acceptance
//   flush                 kill the in-flight operation
//   out_valid/out_ready   result handshake
//   result                registered result word
//   busy                  unit not idle
module rv_muldiv_unit
  import rv_muldiv_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          funct_q, funct_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     opb_q, opb_d;      // multiplicand or divisor
  logic [2*XLEN-1:0]   acc_q, acc_d;      // {product hi, lo} or {remainder, quotient}
  logic [XLEN-1:0]     result_q, result_d;

  logic [XLEN-1:0] mag1, mag2;
  logic            neg, div_zero, ovf, accept;

  rv_muldiv_sign_prep #(.XLEN(XLEN)) u_prep (
    .funct_i    (funct),
    .op1_i      (op1),
    .op2_i      (op2),
    .mag1_o     (mag1),
    .mag2_o     (mag2),
    .neg_o      (neg),
    .div_zero_o (div_zero),
    .ovf_o      (ovf)
  );

  assign accept = in_valid && (state_q == S_IDLE) && !flush;

  // Shift-add: add multiplicand into the high half when the current
  // multiplier bit (acc LSB) is set, then shift the whole register right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
  assign mul_nxt = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]}
                            : {1'b0, acc_q[2*XLEN-1:1]};

  // Restoring divide: shifted remainder needs XLEN+1 bits for the trial.
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] div_nxt;
  assign div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
  assign div_nxt   = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  // Multiply negates the full double-width product before word select;
  // divide negates only the selected quotient/remainder word.
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   word, fix_res;
  always_comb begin
    prod_s = neg_q ? -acc_q : acc_q;
    word   = sel_high(funct_q) ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    if (is_div(funct_q)) fix_res = neg_q ? -word : word;
    else                 fix_res = sel_high(funct_q) ? prod_s[2*XLEN-1:XLEN]
                                                     : prod_s[XLEN-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct_d  = funct_q;
    neg_d    = neg_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: if (accept) begin
        funct_d = funct;
        neg_d   = neg;
        cnt_d   = CNT_W'(XLEN);
        opb_d   = is_div(funct) ? mag2 : mag1;
        acc_d   = {{XLEN{1'b0}}, (is_div(funct) ? mag1 : mag2)};
        state_d = S_CALC;
        // Special cases preload {remainder, quotient} and skip iteration.
        if (div_zero) begin
          acc_d   = {op1, {XLEN{1'b1}}};
          neg_d   = 1'b0;
          state_d = S_FIX;
        end else if (ovf) begin
          acc_d   = {{XLEN{1'b0}}, op1};
          neg_d   = 1'b0;
          state_d = S_FIX;
        end
      end
      S_CALC: begin
        acc_d = is_div(funct_q) ? div_nxt : mul_nxt;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = fix_res;
        state_d  = S_DONE;
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      funct_q  <= '0;
      neg_q    <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct_q  <= funct_d;
      neg_q    <= neg_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
module tb_rv_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0, busy;
  logic [2:0]  funct = '0;
  logic [31:0] op1 = '0, op2 = '0, result;

  logic        h_in_valid = 1'b0, h_in_ready, h_out_valid, h_out_ready = 1'b0, h_busy;
  logic [2:0]  h_funct = '0;
  logic [15:0] h_op1 = '0, h_op2 = '0, h_result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .funct(funct),
    .op1(op1), .op2(op2), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  rv_muldiv_unit #(.XLEN(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .funct(h_funct),
    .op1(h_op1), .op2(h_op2), .flush(1'b0), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .result(h_result), .busy(h_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V M semantics from plain 64-bit / 32-bit arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint          zb = longint'({32'b0, b});
    longint unsigned ua = a;
    longint unsigned ub = b;
    int              ia = a;
    int              ib = b;
    logic [63:0]     p;
    logic            ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * zb; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ov ? a : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ov ? 32'h0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF) && (f == 3'd4 || f == 3'd6);
    return (f[2] && (b == 0 || ov)) ? 2 : 34;
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, count edges (accept edge = 1) to out_valid, optionally
  // hold out_ready low for 'hold' cycles, then consume the result.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    int          lat;
    logic [31:0] r;
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1; funct = f; op1 = a; op2 = b;
    @(negedge clk);
    in_valid = 1'b0; funct = 3'($urandom); op1 = $urandom; op2 = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, ref_lat(f, a, b));
    chk({tag, "_res"}, result, ref_op(f, a, b));
    r = result;
    repeat (hold) begin
      @(negedge clk);
      chk({tag, "_bp_valid"}, out_valid, 1);
      chk({tag, "_bp_res"}, result, r);
      chk({tag, "_bp_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    logic [31:0] saved;
    int          seen;
    int          lat;

    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op("mul",    3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    run_op("mulh",   3'd1, 32'd7, 32'hFFFF_FFFD, 0);
    run_op("mulhu",  3'd3, 32'd7, 32'hFFFF_FFFD, 0);
    run_op("mulhsu", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("mulh_m", 3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("div",    3'd4, -32'd7, 32'd2, 0);
    run_op("rem",    3'd6, -32'd7, 32'd2, 0);
    run_op("divu",   3'd5, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("remu",   3'd7, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("divu0",  3'd5, 32'd5, 32'd0, 0);
    run_op("rem0",   3'd6, 32'd5, 32'd0, 0);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("mulz",   3'd0, 32'h1234_5678, 32'd0, 0);
    run_op("bp",     3'd1, 32'hDEAD_BEEF, 32'h1357_9BDF, 10);

    // Flush at CALC cycle 5
    saved = result;
    @(negedge clk);
    in_valid = 1'b1; funct = 3'd0; op1 = 32'd9; op2 = 32'd9;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("fl_busy_before", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_busy", busy, 0);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_result", result, saved);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("fl_no_valid", seen, 0);

    // Flush coinciding with a request wins over acceptance
    in_valid = 1'b1; flush = 1'b1; funct = 3'd4; op1 = 32'd1; op2 = 32'd0;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("fl_acc_busy", busy, 0);
    run_op("after_fl", 3'd4, -32'd100, 32'd7, 0);

    // Randomized traffic against the reference
    for (int i = 0; i < 40; i++)
      run_op("rnd", 3'($urandom_range(0, 7)), rnd_op(), rnd_op(), $urandom_range(0, 2));

    // Async reset mid-CALC, checked without an intervening clock edge
    @(negedge clk);
    in_valid = 1'b1; funct = 3'd5; op1 = 32'd1000; op2 = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_result", result, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 3'd7, 32'd1000, 32'd3, 0);

    // XLEN=16 instance: MUL 0x00FF * 0x0101, then a signed divide
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      h_in_valid = 1'b1;
      h_funct = (k == 0) ? 3'd0 : 3'd4;
      h_op1   = (k == 0) ? 16'h00FF : 16'hFFF9;
      h_op2   = (k == 0) ? 16'h0101 : 16'h0002;
      @(negedge clk);
      h_in_valid = 1'b0;
      lat = 1;
      while (!h_out_valid && lat < 100) begin
        @(negedge clk);
        lat++;
      end
      chk("x16_lat", lat, 18);
      chk("x16_res", h_result, (k == 0) ? 16'hFFFF : 16'hFFFD);
      h_out_ready = 1'b1;
      @(negedge clk);
      h_out_ready = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
